// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and a
// helper that identifies multiply opcodes.
package alu_pkg;

  localparam logic [5:0] OP_NOOP = 6'h00;
  localparam logic [5:0] OP_MOV  = 6'h10;
  localparam logic [5:0] OP_ADD  = 6'h12;
  localparam logic [5:0] OP_SUB  = 6'h13;
  localparam logic [5:0] OP_OR   = 6'h14;
  localparam logic [5:0] OP_MUL  = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_ADDI = 6'h32;
  localparam logic [5:0] OP_SUBI = 6'h33;
  localparam logic [5:0] OP_ORI  = 6'h34;
  localparam logic [5:0] OP_MULI = 6'h35;
  localparam logic [5:0] OP_LI   = 6'h39;
  localparam logic [5:0] OP_LWI  = 6'h3B;
  localparam logic [5:0] OP_SWI  = 6'h3C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // True for the opcodes that go through the iterative multiplier.
  function automatic logic is_mul(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_BITS bits of b per cycle,
// LSB first. done is asserted during the last iteration cycle and product
// then already carries the final value, so the caller can register it on
// the same edge that retires the last chunk. MUL_BITS must divide SIZE.
module alu_mul_iter #(
  parameter int SIZE     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic                done,
  output logic [2*SIZE-1:0]   product
);

  localparam int N     = SIZE / MUL_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*SIZE-1:0]   a_q;      // multiplicand, pre-shifted to the current chunk weight
  logic [SIZE-1:0]     b_q;      // remaining multiplier bits, consumed from the bottom
  logic [2*SIZE-1:0]   acc_q;
  logic [2*SIZE-1:0]   acc_next;
  logic [2*SIZE-1:0]   pp [MUL_BITS];

  // One partial product per multiplier bit of the current chunk.
  for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
    assign pp[gi] = b_q[gi] ? (a_q << gi) : '0;
  end

  // Accumulator value after retiring the current chunk.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < MUL_BITS; i++) begin
      acc_next = acc_next + pp[i];
    end
  end

  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_next;

  // Load operands on start, then retire one chunk per cycle until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      a_q    <= {{SIZE{1'b0}}, a};
      b_q    <= b;
      acc_q  <= '0;
    end else if (busy_q) begin
      acc_q  <= acc_next;
      a_q    <= a_q << MUL_BITS;
      b_q    <= b_q >> MUL_BITS;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked, registered EX-stage ALU. Single-cycle ops load the one-entry
// output register on the accept edge; multiplies go through alu_mul_iter
// while the FSM sits in ST_MUL and input is blocked.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic [5:0]      Control,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [SIZE-1:0] Out,
  output logic            Zero,
  output logic            Carry,
  output logic            Overflow,
  output logic            Illegal,
  output logic            Busy
);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [SIZE-1:0]   out_q, out_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;

  logic              out_free;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [2*SIZE-1:0] mul_product;

  logic [SIZE:0]     add_w;
  logic [SIZE-1:0]   sub_w;
  logic [SIZE-1:0]   alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              alu_ill;

  assign out_free = !out_valid_q || Out_Ready;
  assign In_Ready = (state_q == ST_IDLE) && out_free;
  assign accept   = In_Valid && In_Ready;

  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = A - B;

  // Single-cycle result and flags decoded from Control.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (Control)
      OP_NOOP: alu_res = '0;
      OP_MOV:  alu_res = A;
      OP_LI, OP_LWI, OP_SWI: alu_res = B;
      OP_ADD, OP_ADDI: begin
        alu_res = add_w[SIZE-1:0];
        alu_c   = add_w[SIZE];
        alu_v   = (A[SIZE-1] == B[SIZE-1]) && (add_w[SIZE-1] != A[SIZE-1]);
      end
      OP_SUB, OP_BEQ, OP_SUBI: begin
        alu_res = sub_w;
        alu_c   = (A < B);
        alu_v   = (A[SIZE-1] != B[SIZE-1]) && (sub_w[SIZE-1] != A[SIZE-1]);
      end
      OP_OR, OP_ORI: alu_res = A | B;
      OP_MUL, OP_MULI: alu_res = '0;  // result comes from the iterative core
      default: alu_ill = 1'b1;
    endcase
  end

  // Next state, multiplier start and output-register update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !Out_Ready;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul(Control)) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_d       = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            ill_d       = alu_ill;
          end
        end
      end
      ST_MUL: begin
        // Nothing can enter the output register while multiplying, so it is free here.
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          out_d       = mul_product[SIZE-1:0];
          zero_d      = (mul_product[SIZE-1:0] == '0);
          carry_d     = 1'b0;
          ovf_d       = |mul_product[2*SIZE-1:SIZE];
          ill_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: result, flags and valid move together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  alu_mul_iter #(
    .SIZE     (SIZE),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  assign Out_Valid = out_valid_q;
  assign Out       = out_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;
  assign Busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes model results into a
// queue at accept time, a negedge monitor pops one per consumed result.
module tb_alu_pipe;

  logic        Clk;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  Control;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out;
  logic        Zero;
  logic        Carry;
  logic        Overflow;
  logic        Illegal;
  logic        Busy;

  alu_pipe #(.SIZE(32), .MUL_BITS(4)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Control   (Control),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out       (Out),
    .Zero      (Zero),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Illegal   (Illegal),
    .Busy      (Busy)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] out;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_bp  = 0;
  bit   or_force = 1;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Out_Ready: either forced by the directed sections or randomised.
  initial begin
    Out_Ready = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      Out_Ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_force;
    end
  end

  // Reference model straight from the opcode table, using 64-bit arithmetic.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, r;
    longint sa, sb_v, sr;
    e = '0;
    e.op = op;
    ua = a; ub = b;
    sa = $signed(a); sb_v = $signed(b);
    r = 0;
    case (op)
      6'h00: r = 0;
      6'h10: r = ua;
      6'h39, 6'h3B, 6'h3C: r = ub;
      6'h12, 6'h32: begin
        r = ua + ub;
        e.c = ((r >> 32) != 0);
        sr = sa + sb_v;
        e.v = (sr > SMAX) || (sr < SMIN);
      end
      6'h13, 6'h20, 6'h33: begin
        r = ua - ub;
        e.c = (ua < ub);
        sr = sa - sb_v;
        e.v = (sr > SMAX) || (sr < SMIN);
      end
      6'h14, 6'h34: r = ua | ub;
      6'h15, 6'h35: begin
        r = ua * ub;
        e.v = ((r >> 32) != 0);
      end
      default: begin
        r = 0;
        e.ill = 1'b1;
      end
    endcase
    e.out = r[31:0];
    e.z = (e.out == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is compared with the oldest expectation.
  always @(negedge Clk) begin
    if (Rst_n && Out_Valid && Out_Ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got out=%h with no pending operation", Out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({Out, Zero, Carry, Overflow, Illegal} !== {e.out, e.z, e.c, e.v, e.ill}) begin
          bad++;
          $display("FAIL result op=%h: got out=%h z=%b c=%b v=%b ill=%b expected out=%h z=%b c=%b v=%b ill=%b",
                   e.op, Out, Zero, Carry, Overflow, Illegal, e.out, e.z, e.c, e.v, e.ill);
        end else begin
          $display("result op=%h out=%h z=%b c=%b v=%b ill=%b ok", e.op, Out, Zero, Carry, Overflow, Illegal);
        end
      end
    end
  end

  // Present one operation (called just after a rising edge) and hold it until accepted.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int waited);
    waited = 0;
    Control = op; A = a; B = b; In_Valid = 1'b1;
    while (waited <= 200) begin
      @(negedge Clk); #1;
      if (In_Ready) break;
      @(posedge Clk); #1;
      waited++;
    end
    if (waited > 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: In_Ready stayed 0, required 1");
    end else if (push) begin
      sb.push_back(model(op, a, b));
    end
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || Out_Valid) && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
    end
  endtask

  logic [5:0]  legal_ops [14] = '{6'h00, 6'h10, 6'h12, 6'h13, 6'h14, 6'h15, 6'h20,
                                  6'h32, 6'h33, 6'h34, 6'h35, 6'h39, 6'h3B, 6'h3C};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC};

  initial begin
    int w;
    bit seen;
    logic [5:0]  op;
    logic [31:0] ra, rb;

    Rst_n = 1'b0; In_Valid = 1'b0; A = '0; B = '0; Control = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_out_valid", Out_Valid, 0);
    chk("reset_out", Out, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_in_ready", In_Ready, 1);
    #2 Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Reset during a multiply aborts it.
    do_op(6'h15, 32'd7, 32'd6, 0, w);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {Out_Valid, Zero, Carry, Overflow, Illegal, Busy}, 0);
    chk("rst_mid_out", Out, 0);
    @(posedge Clk); #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("rst_release_in_ready", In_Ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      seen = seen | Out_Valid;
    end
    chk("rst_no_stale_result", seen, 0);

    // Back-to-back single-cycle stream.
    do_op(6'h12, 32'hFFFF_FFFF, 32'd1, 1, w); chk("stream_wait0", w, 0);
    do_op(6'h13, 32'd3, 32'd5, 1, w);         chk("stream_wait1", w, 0);
    do_op(6'h14, 32'hF0, 32'h0F, 1, w);       chk("stream_wait2", w, 0);
    do_op(6'h10, 32'h1234, 32'd0, 1, w);      chk("stream_wait3", w, 0);
    chk("stream_last_out", Out, 32'h1234);
    wait_drain();

    // Signed overflow corners.
    do_op(6'h12, 32'h7FFF_FFFF, 32'd1, 1, w);
    do_op(6'h13, 32'h8000_0000, 32'd1, 1, w);
    wait_drain();

    // Multiply latency: 8 busy cycles for 32/4.
    do_op(6'h15, 32'h0001_0000, 32'h0003_0000, 1, w);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", Busy, 1);
      chk("mul_in_ready", In_Ready, 0);
      @(posedge Clk); #1;
    end
    chk("mul_done_valid", Out_Valid, 1);
    chk("mul_done_busy", Busy, 0);
    do_op(6'h35, 32'd12, 32'd13, 1, w);
    wait_drain();

    // Backpressure: result held stable, then consume and accept together.
    or_force = 1'b0;
    do_op(6'h12, 32'h11, 32'h22, 1, w);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", In_Ready, 0);
      chk("bp_out_stable", {Out_Valid, Out, Zero, Carry, Overflow}, {1'b1, 32'h33, 1'b0, 1'b0, 1'b0});
      @(posedge Clk); #1;
    end
    or_force = 1'b1;
    do_op(6'h12, 32'd2, 32'd2, 1, w);
    chk("bp_no_bubble_wait", w, 0);
    chk("bp_no_bubble_out", {Out_Valid, Out}, {1'b1, 32'd4});
    wait_drain();

    // Illegal and NOOP.
    do_op(6'h3F, 32'h55, 32'hAA, 1, w);
    do_op(6'h00, 32'h55, 32'hAA, 1, w);
    wait_drain();

    // Randomised traffic with random backpressure.
    rand_bp = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 13)];
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      do_op(op, ra, rb, 1, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clk); #1;
      end
    end
    rand_bp = 0;
    or_force = 1'b1;
    @(posedge Clk); #1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something stalls far beyond the expected run length.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
